// File: rtl/c2_sweep_arbiter.sv
// c2_sweep_arbiter: round-robin time-sharing of one external c2 logic cell.
// A granted requester's 4-bit D configuration is applied to the cell while all
// 16 select vectors are swept, one per cycle. The captured truth table is then
// returned to that requester over a valid/ready handshake.
module c2_sweep_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_cfg,
  output logic [NREQ-1:0]   req_ready,
  output logic              cell_D00,
  output logic              cell_D01,
  output logic              cell_D10,
  output logic              cell_D11,
  output logic              cell_A1,
  output logic              cell_B1,
  output logic              cell_A0,
  output logic              cell_B0,
  input  logic              cell_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       resp_tt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [3:0]     vec;
  logic [15:0]    tt, tt_next;
  logic [3:0]     cfg;
  logic [IDW-1:0] id;

  // Arbiter results: first valid requester at or after rr_ptr, wrapping.
  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW:0]   cand;
  logic           accept;

  // Round-robin scan from rr_ptr; one extra bit in cand absorbs the wrap.
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        grant = cand[IDW-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && found;
  assign busy   = (state != IDLE);

  // Truth table with the current vector's result merged in; bit 15 reaches
  // resp_tt through this path on the final sweep edge.
  always_comb begin
    tt_next      = tt;
    tt_next[vec] = cell_out;
  end

  // State register.
  // NOTE: clocked processes use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus the accept pulse and cell drive.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    {cell_D11, cell_D10, cell_D01, cell_D00} = 4'b0000;
    {cell_A1, cell_B1, cell_A0, cell_B0}     = 4'b0000;
    case (state)
      IDLE: begin
        req_ready[grant] = found;
        if (found) state_next = SWEEP;
      end
      SWEEP: begin
        {cell_D11, cell_D10, cell_D01, cell_D00} = cfg;
        {cell_A1, cell_B1, cell_A0, cell_B0}     = vec;
        if (vec == 4'd15) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: job latch, round-robin pointer, sweep counter, response regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      vec        <= '0;
      tt         <= '0;
      cfg        <= '0;
      id         <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_tt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cfg    <= req_cfg[4*grant +: 4];
            id     <= grant;
            rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
            vec    <= '0;
          end
        end
        SWEEP: begin
          tt  <= tt_next;
          vec <= vec + 4'd1;
          if (vec == 4'd15) begin
            resp_tt    <= tt_next;
            resp_id    <= id;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c2_sweep_arbiter.sv
// Directed bench for c2_sweep_arbiter with a behavioural c2 cell attached.
module tb_c2_sweep_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_cfg;
  logic [NREQ-1:0]   req_ready;
  logic cell_D00, cell_D01, cell_D10, cell_D11;
  logic cell_A1, cell_B1, cell_A0, cell_B0;
  logic              cell_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_tt;
  logic              busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  c2_sweep_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cfg(req_cfg), .req_ready(req_ready),
    .cell_D00(cell_D00), .cell_D01(cell_D01), .cell_D10(cell_D10), .cell_D11(cell_D11),
    .cell_A1(cell_A1), .cell_B1(cell_B1), .cell_A0(cell_A0), .cell_B0(cell_B0),
    .cell_out(cell_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_tt(resp_tt), .busy(busy)
  );

  // Behavioural c2 cell: 4:1 mux with s1 = A1|B1, s0 = A0&B0.
  logic s1, s0;
  assign s1 = cell_A1 | cell_B1;
  assign s0 = cell_A0 & cell_B0;
  always_comb begin
    case ({s1, s0})
      2'b00:   cell_out = cell_D00;
      2'b01:   cell_out = cell_D01;
      2'b10:   cell_out = cell_D10;
      default: cell_out = cell_D11;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cell_bus();
    return {cell_D11, cell_D10, cell_D01, cell_D00, cell_A1, cell_B1, cell_A0, cell_B0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One job on requester r: accept pulse, 17-cycle latency, id/tt, handshake.
  task automatic do_job(input int r, input logic [3:0] cfg, input logic [15:0] exp,
                        input string tag);
    int n;
    @(negedge clk);
    req_cfg[4*r +: 4] = cfg;
    req_valid = NREQ'(1) << r;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << r);
    n = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      #1;
      n++;
    end while (!resp_valid && n < 40);
    check({tag, "_latency"}, n, 17);
    check({tag, "_id"}, 32'(resp_id), r);
    check({tag, "_tt"}, 32'(resp_tt), 32'(exp));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check({tag, "_done"}, {30'd0, resp_valid, busy}, 0);
  endtask

  initial begin
    logic [15:0] rr_tt [NREQ];
    int exp_order [5];
    int n, ng, nr, last_g;

    rst = 1'b1; req_valid = '0; req_cfg = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy",  32'(busy), 0);
    check("reset_rv",    32'(resp_valid), 0);
    check("reset_ready", 32'(req_ready), 0);
    check("reset_cell",  32'(cell_bus()), 0);
    check("reset_tt",    32'(resp_tt), 0);
    check("reset_id",    32'(resp_id), 0);

    // Single-requester truth tables.
    do_job(0, 4'b1000, 16'h8880, "d11");
    do_job(0, 4'b0001, 16'h0007, "d00");
    do_job(0, 4'b1111, 16'hFFFF, "all1");
    do_job(0, 4'b0000, 16'h0000, "all0");
    do_job(0, 4'b0110, 16'h7778, "d01d10");

    // Round-robin with all requesters pending and the consumer always ready.
    do_reset();
    rr_tt[0] = 16'h8880; rr_tt[1] = 16'h0007; rr_tt[2] = 16'h7778; rr_tt[3] = 16'hFFFF;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    @(negedge clk);
    req_cfg = {4'b1111, 4'b0110, 4'b0001, 4'b1000};
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    ng = 0; nr = 0; last_g = 0; n = 0;
    while (nr < 5 && n < 200) begin
      #1;
      if (req_ready != 0 && ng < 5) begin
        check("rr_grant", 32'(req_ready), 32'(1) << exp_order[ng]);
        if (ng > 0) check("rr_spacing", n - last_g, 18);
        last_g = n;
        ng++;
      end
      if (resp_valid) begin
        check("rr_id", 32'(resp_id), exp_order[nr]);
        check("rr_tt", 32'(resp_tt), 32'(rr_tt[exp_order[nr]]));
        nr++;
      end
      @(negedge clk);
      n++;
      if (ng == 5) req_valid = '0;
    end
    check("rr_responses", nr, 5);
    resp_ready = 1'b0;

    // Backpressure: response held while requests wait. rr_ptr is 1 here.
    @(negedge clk);
    req_cfg = {4'b1111, 4'b1111, 4'b0001, 4'b0000};
    req_valid = 4'b0110;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b0100;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_latency", n + 1, 17);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {resp_valid, resp_id, resp_tt, req_ready},
            {1'b1, 2'd1, 16'h0007, 4'b0000});
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    check("bp_accept_cycle_ready", 32'(req_ready), 0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp2_tt", 32'(resp_tt), 32'hFFFF);
    check("bp2_id", 32'(resp_id), 2);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset mid-sweep. rr_ptr is 3, so requester 1 is found after wrapping.
    req_cfg[7:4] = 4'b1111;
    req_valid = 4'b0010;
    #1;
    check("mid_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, busy, resp_valid, |cell_bus()}, 0);
    // rr_ptr cleared: requester 1 wins over 3 (3 would win if rr_ptr were 2).
    req_cfg = {4'b0000, 4'b0000, 4'b0110, 4'b0000};
    req_valid = 4'b1010;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0010);

    // Config changed during the sweep must not affect the result.
    @(negedge clk);
    req_valid = '0;
    req_cfg[7:4] = 4'b1111;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("latched_cfg_tt", 32'(resp_tt), 32'h7778);
    check("latched_cfg_id", 32'(resp_id), 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
